// File: rtl/sram_controller.sv
// sram_controller: sequences one LC-3 memory request into registered async-SRAM strobes, address and DQ drive.
// Define SRAM_CTRL_BYTE_EN to add the i_byte_en lane-select input.
module sram_controller #(
    parameter logic [3:0] WaitStates = 4'd1,
    parameter logic [3:0] AddrHi     = 4'h0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_rw,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
`ifdef SRAM_CTRL_BYTE_EN
    input  logic [1:0]  i_byte_en,
`endif
    output logic [15:0] o_rdata,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_ce,
    output logic        o_oe,
    output logic        o_we,
    output logic        o_lb,
    output logic        o_ub,
    output logic [19:0] o_addr,
    inout  wire  [15:0] io_dq
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ACC   = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_ACC   = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]  r_state, w_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_wdata, r_rdata;
    logic [19:0] r_addr;
    logic [1:0]  r_be, w_be_in, w_be;
    logic        r_ce, r_oe, r_we, r_lb, r_ub, r_dq_oe, r_ready, r_busy;
    logic        w_accept, w_acc, w_cnt_zero;

`ifdef SRAM_CTRL_BYTE_EN
    assign w_be_in = i_byte_en;
`else
    assign w_be_in = 2'b11;
`endif

    assign w_accept   = (r_state == S_IDLE) && i_req;
    assign w_be       = w_accept ? w_be_in : r_be;
    assign w_cnt_zero = (r_cnt == 4'd0);
    assign w_acc      = (w_next != S_IDLE) && (w_next != S_DONE);

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:     w_next = i_req ? (i_rw ? S_WR_SETUP : S_RD_ACC) : S_IDLE;
            S_RD_ACC:   w_next = w_cnt_zero ? S_DONE : S_RD_ACC;
            S_WR_SETUP: w_next = S_WR_ACC;
            S_WR_ACC:   w_next = w_cnt_zero ? S_WR_HOLD : S_WR_ACC;
            S_WR_HOLD:  w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every SRAM-facing signal leaves a flop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_wdata <= 16'h0000;
            r_rdata <= 16'h0000;
            r_addr  <= 20'h00000;
            r_be    <= 2'b00;
            r_ce    <= 1'b1;
            r_oe    <= 1'b1;
            r_we    <= 1'b1;
            r_lb    <= 1'b1;
            r_ub    <= 1'b1;
            r_dq_oe <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ce    <= !w_acc;
            r_oe    <= w_next != S_RD_ACC;
            r_we    <= w_next != S_WR_ACC;
            r_lb    <= !(w_acc && w_be[0]);
            r_ub    <= !(w_acc && w_be[1]);
            r_dq_oe <= w_acc && (w_next != S_RD_ACC);
            r_ready <= w_next == S_DONE;
            r_busy  <= w_next != S_IDLE;
            if (w_accept) begin
                r_be    <= w_be_in;
                r_wdata <= i_wdata;
                r_addr  <= {AddrHi, i_addr};
                r_cnt   <= WaitStates;
            end else if ((r_state == S_RD_ACC || r_state == S_WR_ACC) && !w_cnt_zero) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_RD_ACC && w_cnt_zero)
                r_rdata <= {r_be[1] ? io_dq[15:8] : 8'h00, r_be[0] ? io_dq[7:0] : 8'h00};
        end
    end

    assign io_dq   = r_dq_oe ? r_wdata : 16'hzzzz;
    assign o_rdata = r_rdata;
    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_ce    = r_ce;
    assign o_oe    = r_oe;
    assign o_we    = r_we;
    assign o_lb    = r_lb;
    assign o_ub    = r_ub;
    assign o_addr  = r_addr;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: randomized and directed stimulus against a transaction-level model plus an async SRAM model.
module tb_sram_controller;
    localparam logic [3:0] W  = 4'd1;
    localparam logic [3:0] HI = 4'h0;
`ifdef SRAM_CTRL_BYTE_EN
    localparam bit BE_ON = 1'b1;
`else
    localparam bit BE_ON = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, rw = 1'b0;
    logic [15:0] addr = 16'h0000, wdata = 16'h0000;
    logic [1:0]  be = 2'b11;
    wire  [15:0] dq;
    logic [15:0] rdata;
    logic [19:0] sa;
    logic        ready, busy, ce, oe, we, lb, ub;

    int checks = 0, errors = 0;
    logic chk_en = 1'b0;

    sram_controller #(.WaitStates(W), .AddrHi(HI)) dut (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_rw(rw), .i_addr(addr), .i_wdata(wdata),
`ifdef SRAM_CTRL_BYTE_EN
        .i_byte_en(be),
`endif
        .o_rdata(rdata), .o_ready(ready), .o_busy(busy), .o_ce(ce), .o_oe(oe), .o_we(we),
        .o_lb(lb), .o_ub(ub), .o_addr(sa), .io_dq(dq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lane_mask(input logic [1:0] b);
        return {{8{b[1]}}, {8{b[0]}}};
    endfunction

    // Asynchronous SRAM: drives enabled lanes while read-enabled, commits on WE rising.
    logic [15:0] sram [0:65535];
    logic [15:0] exp_mem [0:65535];
    logic [15:0] p_data, p_addr;
    logic        pend = 1'b0, p_lb, p_ub;
    assign dq = (!ce && !oe && we) ?
                {ub ? 8'hzz : sram[sa[15:0]][15:8], lb ? 8'hzz : sram[sa[15:0]][7:0]} : 16'hzzzz;

    always @(negedge clk) begin
        if (!ce && !we) begin
            pend = 1'b1; p_data = dq; p_addr = sa[15:0]; p_lb = lb; p_ub = ub;
        end else if (pend) begin
            pend = 1'b0;
            if (!p_ub) sram[p_addr][15:8] = p_data[15:8];
            if (!p_lb) sram[p_addr][7:0] = p_data[7:0];
        end
    end

    // Transaction model: m_k counts cycles after the accept edge (first strobe cycle is 1).
    logic        m_act = 1'b0, m_rw = 1'b0;
    int          m_k = 0;
    logic [15:0] m_addr = 16'h0, m_wdata = 16'h0, m_rdata = 16'h0;
    logic [1:0]  m_be = 2'b11;
    logic [19:0] m_sa = 20'h0;

    function automatic int end_k(input logic r);
        return r ? int'(W) + 4 : int'(W) + 2;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0; m_k = 0; m_rdata = 16'h0; m_sa = 20'h0;
        end else if (!m_act) begin
            if (req) begin
                m_act = 1'b1; m_k = 1; m_rw = rw; m_addr = addr; m_wdata = wdata;
                m_be = BE_ON ? be : 2'b11; m_sa = {HI, addr};
            end
        end else begin
            if (!m_rw && m_k == int'(W) + 1) m_rdata = exp_mem[m_addr] & lane_mask(m_be);
            if (m_k == end_k(m_rw)) begin
                m_act = 1'b0;
                if (m_rw) exp_mem[m_addr] = (exp_mem[m_addr] & ~lane_mask(m_be)) | (m_wdata & lane_mask(m_be));
            end else begin
                m_k++;
            end
        end
    end

    logic e_acc, e_we;
    always @(negedge clk) begin
        if (chk_en) begin
            e_acc = m_act && m_k <= (m_rw ? int'(W) + 3 : int'(W) + 1);
            e_we  = m_act && m_rw && m_k >= 2 && m_k <= int'(W) + 2;
            chk("strobes{ce,oe,we,lb,ub,ready,busy}", {25'h0, ce, oe, we, lb, ub, ready, busy},
                {25'h0, !e_acc, !(e_acc && !m_rw), !e_we, !(e_acc && m_be[0]), !(e_acc && m_be[1]),
                 m_act && m_k == end_k(m_rw), m_act});
            chk("addr", {12'h0, sa}, {12'h0, m_sa});
            chk("rdata", {16'h0, rdata}, {16'h0, m_rdata});
            if (e_acc && m_rw) chk("dq_write", {16'h0, dq}, {16'h0, m_wdata});
            if (e_acc && !m_rw)
                chk("dq_read", {16'h0, dq & lane_mask(m_be)}, {16'h0, exp_mem[m_addr] & lane_mask(m_be)});
        end
    end

    task automatic txn(input logic t_rw, input logic [15:0] t_addr, input logic [15:0] t_wdata,
                       input logic [1:0] t_be, input logic mid_change,
                       output int lat, output int we_lo, output int oe_lo);
        req = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata; be = t_be;
        @(posedge clk); #1;
        req = 1'b0;
        if (mid_change) begin addr = 16'h0004; wdata = 16'h1234; rw = ~t_rw; end
        lat = 1; we_lo = 0; oe_lo = 0;
        forever begin
            @(negedge clk);
            if (!we) we_lo++;
            if (!oe) oe_lo++;
            if (ready || lat > 40) break;
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    int lat, we_lo, oe_lo, n_ready, n_idle;
    logic saw_ready;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram[i] = 16'(i) ^ 16'hC3A5;
            exp_mem[i] = 16'(i) ^ 16'hC3A5;
        end
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("reset_strobes", {27'h0, ce, oe, we, lb, ub}, 32'h1F);
        chk("reset_rdata", {16'h0, rdata}, 32'h0);
        chk("reset_ready_busy", {30'h0, ready, busy}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        req = 1'b1; rw = 1'b1; addr = 16'h0007; wdata = 16'h1111;
        @(posedge clk); #1 req = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_strobes", {27'h0, ce, oe, we, lb, ub}, 32'h1F);
        chk("abort_ready", {31'h0, ready}, 32'h0);
        chk("abort_rdata", {16'h0, rdata}, 32'h0);
        chk("abort_mem7", {16'h0, sram[7]}, 32'hC3A2);
        @(posedge clk); #1 rst = 1'b0;

        txn(1'b1, 16'h0003, 16'hBEEF, 2'b11, 1'b0, lat, we_lo, oe_lo);
        chk("wr_latency", lat, 5);
        chk("wr_we_low_cycles", we_lo, 2);
        chk("wr_oe_low_cycles", oe_lo, 0);
        chk("wr_addr", {12'h0, sa}, 32'h00003);
        chk("wr_mem3", {16'h0, sram[3]}, 32'hBEEF);

        txn(1'b0, 16'h0003, 16'h0000, 2'b11, 1'b0, lat, we_lo, oe_lo);
        chk("rd_latency", lat, 3);
        chk("rd_oe_low_cycles", oe_lo, 2);
        chk("rd_we_low_cycles", we_lo, 0);
        chk("rd_rdata", {16'h0, rdata}, 32'hBEEF);

        txn(1'b1, 16'h0003, 16'h5555, 2'b11, 1'b0, lat, we_lo, oe_lo);
        txn(1'b1, 16'h0003, 16'hBEEF, 2'b11, 1'b1, lat, we_lo, oe_lo);
        chk("mid_mem3", {16'h0, sram[3]}, 32'hBEEF);
        chk("mid_mem4", {16'h0, sram[4]}, 32'hC3A1);
        chk("mid_rdata_kept", {16'h0, rdata}, 32'hBEEF);

        req = 1'b1; rw = 1'b0; addr = 16'h0005; wdata = 16'h0A0A; be = 2'b11;
        n_ready = 0; n_idle = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            saw_ready = ready;
            if (ready) n_ready++;
            if (!busy) n_idle++;
            @(posedge clk); #1;
            if (saw_ready) rw = ~rw;
        end
        req = 1'b0;
        chk("b2b_ready_count", n_ready, 8);
        chk("b2b_idle_count", n_idle, 8);
        chk("b2b_mem5", {16'h0, sram[5]}, 32'h0A0A);

`ifdef SRAM_CTRL_BYTE_EN
        txn(1'b1, 16'h0003, 16'hAA55, 2'b01, 1'b0, lat, we_lo, oe_lo);
        chk("be_mem3", {16'h0, sram[3]}, 32'hBE55);
        txn(1'b0, 16'h0003, 16'h0000, 2'b10, 1'b0, lat, we_lo, oe_lo);
        chk("be_rdata", {16'h0, rdata}, 32'hBE00);
        txn(1'b1, 16'h0003, 16'h1234, 2'b00, 1'b0, lat, we_lo, oe_lo);
        chk("be_none_latency", lat, 5);
        chk("be_none_mem3", {16'h0, sram[3]}, 32'hBE55);
`endif

        for (int c = 0; c < 600; c++) begin
            req = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            addr = 16'($urandom_range(0, 15));
            wdata = 16'($urandom);
            be = 2'($urandom);
            @(posedge clk); #1;
        end
        req = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) chk("final_mem", {16'h0, sram[i]}, {16'h0, exp_mem[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
